// File: rtl/md_motion_pkg.sv
// -----------------------------------------------------------------------------
// md_motion_pkg
// Shared types and defaults for the motion-update broadcast controller.
//   motion_state_e : phase sequencing states (also exported for debug)
//   DATA_WIDTH_DEF / CELL_ID_WIDTH_DEF : default component / coordinate widths
//   cell_id_t      : {cell_x, cell_y, cell_z} at the default coordinate width
// -----------------------------------------------------------------------------
package md_motion_pkg;

  localparam int DATA_WIDTH_DEF    = 32;
  localparam int CELL_ID_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BROADCAST = 2'd1,
    SWAP_WAIT = 2'd2,
    DONE      = 2'd3
  } motion_state_e;

  typedef logic [3*CELL_ID_WIDTH_DEF-1:0] cell_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Grants the first asserted request
// at or after the pointer, wrapping modulo N.
//   req_i   [N]  : request vector
//   ptr_i   [IW] : highest-priority index this cycle (must be < N)
//   grant_o [N]  : one-hot grant, all zero when no request
//   idx_o   [IW] : index of the granted request (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  logic [IW-1:0] lane;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    lane    = '0;
    for (int k = 0; k < N; k++) begin
      lane = IW'((int'(ptr_i) + k) % N);
      if (!found && req_i[lane]) begin
        found         = 1'b1;
        grant_o[lane] = 1'b1;
        idx_o         = lane;
      end
    end
  end

endmodule

// File: rtl/motion_update_broadcast_ctrl.sv
// -----------------------------------------------------------------------------
// motion_update_broadcast_ctrl
// Sequences the motion-update phase of the double-buffered position caches:
// holds motion_update_enable while requesters drain their particles onto a
// single broadcast bus (round-robin), waits for the caches to swap buffers,
// then pulses done.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   start                : one-cycle phase start, only honoured in IDLE
//   req_valid[N]         : lane i holds a particle
//   req_data[N*3*DW]     : lane i = {posz, posy, posx}
//   req_dst_cell[N*3*CW] : lane i = {cell_x, cell_y, cell_z}
//   req_done[N]          : lane i has nothing more this phase (level)
//   req_ready[N]         : one-hot combinational grant
//   motion_update_enable : registered, high for the whole BROADCAST state
//   out_data, out_data_dst_cell, out_data_valid : registered broadcast bus
//   busy                 : state != IDLE
//   done                 : one-cycle end-of-phase pulse
//   broadcast_count      : saturating count of particles sent this phase
//   dbg_state            : current FSM state
//
// Handshake: a particle moves on lane i in the cycle where req_valid[i] and
// req_ready[i] are both high. req_valid must not depend on req_ready; the
// requester presents its next particle (or drops valid) in the following
// cycle. The accepted particle appears on out_* one cycle later.
// -----------------------------------------------------------------------------
module motion_update_broadcast_ctrl
  import md_motion_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int CELL_ID_WIDTH = CELL_ID_WIDTH_DEF,
  parameter int NUM_REQ       = 4,
  parameter int SWAP_CYCLES   = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*3*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0] req_dst_cell,
  input  logic [NUM_REQ-1:0]                 req_done,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]            out_data,
  output logic [3*CELL_ID_WIDTH-1:0]         out_data_dst_cell,
  output logic                               out_data_valid,
  output logic                               busy,
  output logic                               done,
  output logic [CNT_WIDTH-1:0]               broadcast_count,
  output motion_state_e                      dbg_state
);

  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LANE_W = 3 * DATA_WIDTH;
  localparam int CELL_W = 3 * CELL_ID_WIDTH;
  localparam int SW_W   = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;

  localparam logic [SW_W-1:0] SWAP_LOAD = SW_W'(SWAP_CYCLES - 1);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_REQ - 1);

  motion_state_e         state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [SW_W-1:0]       swap_q, swap_d;
  logic                  enable_q;
  logic [LANE_W-1:0]     out_data_q;
  logic [CELL_W-1:0]     out_cell_q;
  logic                  out_valid_q;

  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         grant_idx;
  logic                  xfer;
  logic [LANE_W-1:0]     sel_data;
  logic [CELL_W-1:0]     sel_cell;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  // One-hot AND-OR lane mux driven by the arbiter grant.
  always_comb begin
    sel_data = '0;
    sel_cell = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data = sel_data | ({LANE_W{grant[i]}} & req_data[i*LANE_W +: LANE_W]);
      sel_cell = sel_cell | ({CELL_W{grant[i]}} & req_dst_cell[i*CELL_W +: CELL_W]);
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    swap_d    = swap_q;
    req_ready = '0;
    xfer      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = BROADCAST;
        end
      end
      BROADCAST: begin
        req_ready = grant;
        if (|req_valid) begin
          // Any valid lane is granted, even one whose done is already high.
          xfer  = 1'b1;
          ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);
          if (cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end else if (&req_done) begin
          swap_d  = SWAP_LOAD;
          state_d = SWAP_WAIT;
        end
      end
      SWAP_WAIT: begin
        if (swap_q == '0) begin
          state_d = DONE;
        end else begin
          swap_d = swap_q - SW_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      swap_q      <= '0;
      enable_q    <= 1'b0;
      out_data_q  <= '0;
      out_cell_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      swap_q      <= swap_d;
      // Enable tracks the next state so it rises with the first BROADCAST
      // cycle and falls with the first SWAP_WAIT cycle.
      enable_q    <= (state_d == BROADCAST);
      out_data_q  <= xfer ? sel_data : '0;
      out_cell_q  <= xfer ? sel_cell : '0;
      out_valid_q <= xfer;
    end
  end

  assign motion_update_enable = enable_q;
  assign out_data             = out_data_q;
  assign out_data_dst_cell    = out_cell_q;
  assign out_data_valid       = out_valid_q;
  assign busy                 = (state_q != IDLE);
  assign done                 = (state_q == DONE);
  assign broadcast_count      = cnt_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_motion_update_broadcast_ctrl.sv
// -----------------------------------------------------------------------------
// tb_motion_update_broadcast_ctrl
// Directed bench: a per-cycle vector table for a full phase (round-robin over
// four lanes, late done with a final particle, start during SWAP_WAIT, an
// empty phase), followed by hand-written reset and two-lane sequences.
// -----------------------------------------------------------------------------
module tb_motion_update_broadcast_ctrl;
  import md_motion_pkg::*;

  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int N    = 4;
  localparam int SW   = 3;
  localparam int CNTW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [N-1:0]      req_valid;
  logic [N*3*DW-1:0] req_data;
  logic [N*3*CW-1:0] req_dst_cell;
  logic [N-1:0]      req_done;
  logic [N-1:0]      req_ready;
  logic              motion_update_enable;
  logic [3*DW-1:0]   out_data;
  logic [3*CW-1:0]   out_data_dst_cell;
  logic              out_data_valid;
  logic              busy;
  logic              done;
  logic [CNTW-1:0]   broadcast_count;
  motion_state_e     dbg_state;

  motion_update_broadcast_ctrl #(
    .DATA_WIDTH    (DW),
    .CELL_ID_WIDTH (CW),
    .NUM_REQ       (N),
    .SWAP_CYCLES   (SW),
    .CNT_WIDTH     (CNTW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .req_valid            (req_valid),
    .req_data             (req_data),
    .req_dst_cell         (req_dst_cell),
    .req_done             (req_done),
    .req_ready            (req_ready),
    .motion_update_enable (motion_update_enable),
    .out_data             (out_data),
    .out_data_dst_cell    (out_data_dst_cell),
    .out_data_valid       (out_data_valid),
    .busy                 (busy),
    .done                 (done),
    .broadcast_count      (broadcast_count),
    .dbg_state            (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  int checks = 0;
  int errors = 0;

  function automatic logic [3*DW-1:0] lane_data(input int i);
    if (i < 0) return '0;
    return {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i)};
  endfunction

  function automatic cell_id_t lane_cell(input int i);
    if (i < 0) return '0;
    return {4'(i + 1), 4'(i + 5), 4'(i + 9)};
  endfunction

  task automatic chk(input string name, input int row, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %0h expected %0h", name, row, act, exp);
    end
  endtask

  // Check the registered broadcast bus against the lane expected (-1 = idle).
  task automatic chk_bus(input int row, input int lane);
    chk("out_data_valid", row, 128'(out_data_valid), 128'(lane >= 0));
    chk("out_data", row, 128'(out_data), 128'(lane_data(lane)));
    chk("out_data_dst_cell", row, 128'(out_data_dst_cell), 128'(lane_cell(lane)));
  endtask

  task automatic chk_all_zero(input string tag, input int row);
    chk({tag, "_ready"}, row, 128'(req_ready), 128'(0));
    chk({tag, "_enable"}, row, 128'(motion_update_enable), 128'(0));
    chk_bus(row, -1);
    chk({tag, "_busy"}, row, 128'(busy), 128'(0));
    chk({tag, "_done"}, row, 128'(done), 128'(0));
    chk({tag, "_count"}, row, 128'(broadcast_count), 128'(0));
    chk({tag, "_state"}, row, 128'(dbg_state), 128'(IDLE));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic s, input logic [N-1:0] v, input logic [N-1:0] d);
    @(posedge clk);
    #1;
    start     = s;
    req_valid = v;
    req_done  = d;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         start;
    logic [N-1:0] valid;
    logic [N-1:0] dne;
    logic [N-1:0] ready;
    logic         en;
    int           lane;
    logic         busy;
    logic         done;
    logic [CNTW-1:0] cnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic s, input logic [N-1:0] v, input logic [N-1:0] d,
                              input logic [N-1:0] r, input logic en, input int lane,
                              input logic b, input logic dn, input int cnt);
    vec_t x;
    x.start = s; x.valid = v; x.dne = d; x.ready = r; x.en = en;
    x.lane = lane; x.busy = b; x.done = dn; x.cnt = CNTW'(cnt);
    return x;
  endfunction

  initial begin
    int rem[N];
    int exp_q[$];
    int prev;
    int seen_done;
    int done_cyc;
    logic [N-1:0] v;
    logic [N-1:0] d;
    logic [N-1:0] exp_ready;

    //            st  valid    done     ready    en  lane busy done cnt
    tbl[0]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 0, -1, 0, 0, 0);
    tbl[1]  = mk(0, 4'b1111, 4'b0000, 4'b0001, 1, -1, 1, 0, 0);
    tbl[2]  = mk(0, 4'b1111, 4'b0000, 4'b0010, 1,  0, 1, 0, 1);
    tbl[3]  = mk(0, 4'b1111, 4'b0000, 4'b0100, 1,  1, 1, 0, 2);
    tbl[4]  = mk(0, 4'b1111, 4'b0000, 4'b1000, 1,  2, 1, 0, 3);
    tbl[5]  = mk(0, 4'b0010, 4'b1111, 4'b0010, 1,  3, 1, 0, 4); // last particle, all done
    tbl[6]  = mk(0, 4'b0000, 4'b1111, 4'b0000, 1,  1, 1, 0, 5); // exit condition
    tbl[7]  = mk(1, 4'b0000, 4'b1111, 4'b0000, 0, -1, 1, 0, 5); // start in SWAP_WAIT
    tbl[8]  = mk(0, 4'b0000, 4'b1111, 4'b0000, 0, -1, 1, 0, 5);
    tbl[9]  = mk(0, 4'b0000, 4'b1111, 4'b0000, 0, -1, 1, 0, 5);
    tbl[10] = mk(0, 4'b0000, 4'b1111, 4'b0000, 0, -1, 1, 1, 5); // done pulse
    tbl[11] = mk(0, 4'b0000, 4'b1111, 4'b0000, 0, -1, 0, 0, 5);
    tbl[12] = mk(1, 4'b0000, 4'b1111, 4'b0000, 0, -1, 0, 0, 5); // fresh phase, empty
    tbl[13] = mk(0, 4'b0000, 4'b1111, 4'b0000, 1, -1, 1, 0, 0);
    tbl[14] = mk(0, 4'b0000, 4'b1111, 4'b0000, 0, -1, 1, 0, 0);
    tbl[15] = mk(0, 4'b0000, 4'b1111, 4'b0000, 0, -1, 1, 0, 0);
    tbl[16] = mk(0, 4'b0000, 4'b1111, 4'b0000, 0, -1, 1, 0, 0);
    tbl[17] = mk(0, 4'b0000, 4'b1111, 4'b0000, 0, -1, 1, 1, 0);
    tbl[18] = mk(0, 4'b0000, 4'b1111, 4'b0000, 0, -1, 0, 0, 0);

    for (int i = 0; i < N; i++) begin
      req_data[i*3*DW +: 3*DW]     = lane_data(i);
      req_dst_cell[i*3*CW +: 3*CW] = lane_cell(i);
    end
    rst = 1'b1; start = 1'b0; req_valid = '0; req_done = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset", -1);
    @(posedge clk);
    #1 rst = 1'b0;

    // ---- table-driven phase ----
    for (int r = 0; r < 19; r++) begin
      drive(tbl[r].start, tbl[r].valid, tbl[r].dne);
      @(negedge clk);
      chk("req_ready", r, 128'(req_ready), 128'(tbl[r].ready));
      chk("enable", r, 128'(motion_update_enable), 128'(tbl[r].en));
      chk_bus(r, tbl[r].lane);
      chk("busy", r, 128'(busy), 128'(tbl[r].busy));
      chk("done", r, 128'(done), 128'(tbl[r].done));
      chk("count", r, 128'(broadcast_count), 128'(tbl[r].cnt));
    end

    // ---- reset in the middle of BROADCAST ----
    drive(1'b1, 4'b1111, 4'b0000);
    for (int c = 1; c < 5; c++) drive(1'b0, 4'b1111, 4'b0000);
    @(posedge clk);
    #1;
    chk("pre_rst_count", 5, 128'(broadcast_count), 128'(4));
    chk("pre_rst_valid", 5, 128'(out_data_valid), 128'(1));
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst", 5);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 4'b1111, 4'b0000);
      @(negedge clk);
      chk("post_rst_done", c, 128'(done), 128'(0));
      chk("post_rst_busy", c, 128'(busy), 128'(0));
      chk("post_rst_ready", c, 128'(req_ready), 128'(0));
    end

    // ---- lanes 0 and 2, three particles each, pointer 0 after reset ----
    rem = '{3, 0, 3, 0};
    exp_q = {0, 2, 0, 2, 0, 2};
    prev = -1;
    seen_done = 0;
    done_cyc = -1;
    drive(1'b1, 4'b0000, 4'b1010);
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = (rem[i] > 0);
        d[i] = (rem[i] == 0);
      end
      drive(1'b0, v, d);
      @(negedge clk);
      exp_ready = (v != '0 && exp_q.size() > 0) ? N'(1 << exp_q[0]) : '0;
      chk("alt_ready", c, 128'(req_ready), 128'(exp_ready));
      chk_bus(c, prev);
      if (prev >= 0) chk("alt_enable", c, 128'(motion_update_enable), 128'(1));
      if (exp_ready != '0) begin
        prev = exp_q.pop_front();
        rem[prev] = rem[prev] - 1;
      end else begin
        prev = -1;
      end
      if (done) begin
        seen_done++;
        done_cyc = c;
        chk("alt_count", c, 128'(broadcast_count), 128'(6));
      end
      if (seen_done > 0 && !busy) break;
    end
    chk("alt_done_pulses", 0, 128'(seen_done), 128'(1));
    chk("alt_done_cycle", 0, 128'(done_cyc), 128'(10));
    chk("alt_grants_left", 0, 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
